// File: rtl/demux2_skid_stage.sv
// demux2_skid_stage: registered 1-to-2 steering stage.
// One upstream word stream is routed per word to output A (in_sel = 1) or
// output B (in_sel = 0). Each output owns a small FIFO, so a stalled consumer
// never blocks words bound for the other output.
//
// Optional build macro: DEMUX2_FLUSH_EN adds a synchronous 'flush' input that
// empties both FIFOs and blocks any same-cycle push or pop.
//
// Handshake semantics (all three ports): a word moves on a rising clk edge
// exactly when valid and ready are both 1 at that edge; valid never depends
// on ready; in_ready is derived only from stored occupancy, so there is no
// combinational path from a_ready/b_ready to in_ready and none from the
// input to the outputs.
module demux2_skid_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PTRW  = 1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DEMUX2_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [PTRW:0]    a_count,
    output logic [PTRW:0]    b_count
);

    localparam logic [PTRW:0]   FULL_CNT = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);

    // Storage (intentionally not reset).
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];

    // Pointers and occupancy per FIFO.
    logic [PTRW-1:0] wr_a, rd_a;
    logic [PTRW-1:0] wr_b, rd_b;
    logic [PTRW:0]   cnt_a, cnt_b;

    // Set on the first write after reset; until then the data outputs show 0
    // instead of uninitialised storage.
    logic loaded_a, loaded_b;

    logic flush_i;
    logic push_a, push_b;
    logic pop_a, pop_b;

`ifdef DEMUX2_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Upstream ready: room in the selected FIFO, judged on stored occupancy
    // only, so a full FIFO being popped this cycle still refuses the word.
    always_comb begin
        in_ready = 1'b0;
        if (!reset && !flush_i) begin
            in_ready = in_sel ? (cnt_a != FULL_CNT) : (cnt_b != FULL_CNT);
        end
    end

    // Handshake qualifiers for every FIFO port.
    always_comb begin
        push_a = in_valid & in_ready & in_sel;
        push_b = in_valid & in_ready & ~in_sel;
        pop_a  = a_valid & a_ready & ~flush_i;
        pop_b  = b_valid & b_ready & ~flush_i;
    end

    // Output view: valid from occupancy, data straight from the head slot.
    always_comb begin
        a_valid = (cnt_a != '0);
        b_valid = (cnt_b != '0);
        a_count = cnt_a;
        b_count = cnt_b;
        a_data  = loaded_a ? mem_a[rd_a] : '0;
        b_data  = loaded_b ? mem_b[rd_b] : '0;
    end

    // FIFO A storage write.
    always_ff @(posedge clk) begin
        if (push_a) begin
            mem_a[wr_a] <= in_data;
        end
    end

    // FIFO B storage write.
    always_ff @(posedge clk) begin
        if (push_b) begin
            mem_b[wr_b] <= in_data;
        end
    end

    // FIFO A pointers and count; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_a     <= '0;
            rd_a     <= '0;
            cnt_a    <= '0;
            loaded_a <= 1'b0;
        end else if (flush_i) begin
            wr_a  <= '0;
            rd_a  <= '0;
            cnt_a <= '0;
        end else begin
            if (push_a) begin
                wr_a     <= wr_a + PTR_ONE;
                loaded_a <= 1'b1;
            end
            if (pop_a) begin
                rd_a <= rd_a + PTR_ONE;
            end
            case ({push_a, pop_a})
                2'b10:   cnt_a <= cnt_a + CNT_ONE;
                2'b01:   cnt_a <= cnt_a - CNT_ONE;
                default: cnt_a <= cnt_a;
            endcase
        end
    end

    // FIFO B pointers and count; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_b     <= '0;
            rd_b     <= '0;
            cnt_b    <= '0;
            loaded_b <= 1'b0;
        end else if (flush_i) begin
            wr_b  <= '0;
            rd_b  <= '0;
            cnt_b <= '0;
        end else begin
            if (push_b) begin
                wr_b     <= wr_b + PTR_ONE;
                loaded_b <= 1'b1;
            end
            if (pop_b) begin
                rd_b <= rd_b + PTR_ONE;
            end
            case ({push_b, pop_b})
                2'b10:   cnt_b <= cnt_b + CNT_ONE;
                2'b01:   cnt_b <= cnt_b - CNT_ONE;
                default: cnt_b <= cnt_b;
            endcase
        end
    end

endmodule

// File: tb/tb_demux2_skid_stage.sv
// Testbench for demux2_skid_stage: per-cycle vector table plus hand-written
// sequences for async reset, pointer wrap and (when built) flush. A queue per
// output holds the words expected to emerge, in order.
module tb_demux2_skid_stage;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int PTRW  = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] in_data;
    logic             in_sel, in_valid, in_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic [PTRW:0]    a_count, b_count;

    demux2_skid_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef DEMUX2_FLUSH_EN
        .flush   (flush),
`endif
        .in_data (in_data),
        .in_sel  (in_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .a_count (a_count),
        .b_count (b_count)
    );

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_a_q[$];
    logic [WIDTH-1:0] exp_b_q[$];
    int total = 0;
    int bad   = 0;
    bit last_accept;
    int b_pops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        if (reset || flush) return 1'b0;
        return in_sel ? (exp_a_q.size() < DEPTH) : (exp_b_q.size() < DEPTH);
    endfunction

    // Compare every output against the model (called on the falling edge).
    task automatic check_model();
        check("in_ready", 32'(in_ready), 32'(model_ready()));
        check("a_count", 32'(a_count), 32'(exp_a_q.size()));
        check("b_count", 32'(b_count), 32'(exp_b_q.size()));
        check("a_valid", 32'(a_valid), 32'(exp_a_q.size() != 0));
        check("b_valid", 32'(b_valid), 32'(exp_b_q.size() != 0));
        if (exp_a_q.size() != 0) check("a_data", a_data, exp_a_q[0]);
        if (exp_b_q.size() != 0) check("b_data", b_data, exp_b_q[0]);
    endtask

    // Advance the model at the rising edge using only bench-side values.
    task automatic update_model();
        logic acc;
        acc = in_valid && model_ready();
        last_accept = 1'b0;
        if (flush) begin
            exp_a_q.delete();
            exp_b_q.delete();
            return;
        end
        if (exp_a_q.size() != 0 && a_ready) void'(exp_a_q.pop_front());
        if (exp_b_q.size() != 0 && b_ready) begin
            void'(exp_b_q.pop_front());
            b_pops++;
        end
        if (acc) begin
            if (in_sel) exp_a_q.push_back(in_data);
            else        exp_b_q.push_back(in_data);
        end
        last_accept = acc;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic ar, input logic br);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        s;
        logic [31:0] d;
        logic        ar;
        logic        br;
        logic        rdy;   // in_ready expected during this row
        logic [1:0]  ac;    // a_count expected during this row
        logic [1:0]  bc;    // b_count expected during this row
    } vec_t;

    vec_t vecs[19];

    initial begin
        #100000;
        $display("FAIL timeout: got=running want=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Routing, backpressure isolation, full-plus-pop, simultaneous ops.
        vecs[0]  = '{1'b1, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd0, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[5]  = '{1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[6]  = '{1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 32'hB1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 1'b0, 2'd2, 2'd1};
        vecs[9]  = '{1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0};
        vecs[10] = '{1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 2'd2, 2'd0};
        vecs[12] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[14] = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[15] = '{1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[16] = '{1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1};
        vecs[17] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
        vecs[18] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd0, 2'd0};

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        #2;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset a_data", a_data, 32'h0);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle in_ready", 32'(in_ready), 32'd1);
        check("idle a_data", a_data, 32'h0);
        check("idle b_data", b_data, 32'h0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].ar, vecs[i].br);
            @(negedge clk);
            check_model();
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d a_count", i), 32'(a_count), 32'(vecs[i].ac));
            check($sformatf("vec%0d b_count", i), 32'(b_count), 32'(vecs[i].bc));
            @(posedge clk);
            update_model();
            #1;
        end

        // ---------------- async reset mid-run ----------------
        drive(1'b1, 1'b1, 32'hC1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 32'hC2, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre-reset a_count", 32'(a_count), 32'd2);
        reset = 1'b1;
        exp_a_q.delete();
        exp_b_q.delete();
        #1;
        check("mid reset a_valid", 32'(a_valid), 32'd0);
        check("mid reset a_count", 32'(a_count), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        check("mid reset a_data", a_data, 32'h0);
        #1;
        reset = 1'b0;
        in_sel = 1'b1;
        #1;
        check("post reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---------------- wrap-around on B ----------------
        begin
            int idx;
            int cyc;
            idx    = 0;
            cyc    = 0;
            b_pops = 0;
            while ((idx < 10 || exp_b_q.size() != 0) && cyc < 200) begin
                drive(idx < 10, 1'b0, 32'h100 + 32'(idx), 1'b0, cyc[0]);
                @(negedge clk);
                check_model();
                check("wrap b_count<=2", 32'(b_count <= 2'd2), 32'd1);
                @(posedge clk);
                update_model();
                if (last_accept) idx++;
                #1;
                cyc++;
            end
            check("wrap words accepted", 32'(idx), 32'd10);
            check("wrap words emerged", 32'(b_pops), 32'd10);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle();

`ifdef DEMUX2_FLUSH_EN
        // ---------------- flush ----------------
        drive(1'b1, 1'b1, 32'hD1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 32'hD2, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 32'hD3, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 32'hEE, 1'b1, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        check("flush in_ready", 32'(in_ready), 32'd0);
        check("pre-flush a_count", 32'(a_count), 32'd2);
        check("pre-flush b_count", 32'(b_count), 32'd1);
        @(posedge clk);
        update_model();
        #1;
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_model();
        check("post-flush a_count", 32'(a_count), 32'd0);
        check("post-flush b_count", 32'(b_count), 32'd0);
        check("post-flush b_valid", 32'(b_valid), 32'd0);
        @(posedge clk);
        update_model();
        #1;
`endif

        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux2_skid_stage.md
Name: demux2_skid_stage

Overview:
- Registered 1-to-2 steering stage for 32-bit words; the write-direction counterpart of the datapath 2:1 select.
- One upstream valid/ready stream is routed per word to destination A or B by a sideband select.
- Each destination has a small FIFO, so a stalled consumer never blocks words bound for the other one.
- Used between the writeback result bus and the register-file / HI-LO consumers in the pipelined core.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, 2..8.
- PTRW, 1, pointer width, log2(DEPTH); must be kept consistent with DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_data  input  WIDTH  upstream word.
- in_sel  input  1  1 routes to A, 0 routes to B; sampled with in_data.
- in_valid  input  1  upstream word present.
- in_ready  output  1  stage can accept the current word.
- a_data  output  WIDTH  head word of FIFO A.
- a_valid  output  1  FIFO A non-empty.
- a_ready  input  1  consumer A takes the head.
- b_data  output  WIDTH  head word of FIFO B.
- b_valid  output  1  FIFO B non-empty.
- b_ready  input  1  consumer B takes the head.
- a_count  output  PTRW+1  occupancy of FIFO A.
- b_count  output  PTRW+1  occupancy of FIFO B.

Behaviour:
- Reset (async, active-high): pointers and counts go to 0; a_valid, b_valid, a_count, b_count = 0; a_data, b_data = 0; in_ready = 0 while reset is asserted.
- Storage array contents are not reset. Reset may be asserted mid-transfer; any in-flight words are discarded.
- in_ready is combinational: in_sel ? (a_count != DEPTH) : (b_count != DEPTH). It depends only on stored occupancy, not on same-cycle pops.
- Accept: in_valid & in_ready at a clk edge writes in_data into the selected FIFO.
- Pop: a_valid & a_ready at a clk edge pops A; B behaves the same way.
- Latency: an accepted word is visible on x_data/x_valid in the next cycle. There is no combinational in-to-out path.
- Ordering: FIFO order within each output. No ordering relation between A and B.
- Push and pop on the same FIFO in one cycle (non-empty, non-full): count is unchanged and both pointers advance.
- Full FIFO with a same-cycle pop: in_ready stays 0 for that FIFO's words that cycle. The push is not bypassed; one bubble is accepted.
- Empty FIFO with a push: x_valid rises next cycle; there is no fall-through.
- Pointer wrap: pointers are modulo DEPTH and count saturates logically at DEPTH. Overflow or underflow never occurs because push is gated by in_ready and pop by x_valid.
- Simultaneous pops on A and B plus a push to either are all legal in one cycle.
- x_data while x_valid = 0 shows the stale storage value; consumers must ignore it.

Optional Feature:
- Macro: DEMUX2_FLUSH_EN.
- Defined: adds input port flush (1 bit, synchronous, active-high). On a clk edge with flush = 1:
  - both FIFOs empty: counts become 0 and a_valid, b_valid become 0 next cycle;
  - any same-cycle push or pop is ignored;
  - in_ready is forced to 0 during flush.
- Not defined: the port is absent and FIFO state changes only through push, pop and reset.

Test Plan:
- Reset then idle: with reset high mid-run (A holding 2 words), the outputs are immediately a_valid = 0, a_count = 0, in_ready = 0. After release with in_sel = 1, in_ready = 1.
- Routing: push 0x0000_0011 with sel = 1, then 0x0000_0022 with sel = 0, ready high on both outputs.
  - Required: a_data = 0x11 with a_valid one cycle after its accept.
  - Required: b_data = 0x22 one cycle after its accept.
  - No cross-delivery.
- Backpressure isolation: a_ready = 0, push 0xA1, 0xA2 to A.
  - a_count = 2, and in_ready = 0 when sel = 1.
  - Push 0xB1 with sel = 0: accepted, b_valid next cycle.
  - Raise a_ready: 0xA1 then 0xA2 emerge in order.
- Full plus pop: A full and a_ready = 1 with in_valid, sel = 1 → no accept that cycle. Next cycle a_count = 1, then the push is accepted.
- Wrap-around: stream 10 words 0x100..0x109 to B, with b_ready toggling every cycle. All 10 emerge in order, b_count never exceeds 2.
- DEMUX2_FLUSH_EN: A holds 2 words, B holds 1, pulse flush with in_valid = 1. Next cycle a_count = b_count = 0, and the concurrent word is not stored.
